resv_sched: RTL and testbench

- Controller for one reservation station built from DEPTH cells: owns occupancy, insert address, shift/compaction address and issue arbitration.
- Accepts one dispatched uop per cycle from the decoder. Picks at most one ready cell per cycle (oldest first) for pipe 0 or pipe 1, round-robin between pipes.
- Drives the cells' addr_insert, addr_shift and clear inputs.

---
 rtl/resv_pkg.sv | 19 +
 rtl/resv_prio_pick.sv | 22 ++
 rtl/resv_sched.sv | 131 +++++++++++++
 tb/tb_resv_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/resv_pkg.sv
// Shared constants and types for the reservation-station scheduler.
package resv_pkg;

   localparam int W_ident = 4;
   localparam int DEPTH   = 8;
   localparam int W_cnt   = 4;

   // All-ones identifier marks an empty slot on candidate and address buses.
   localparam logic [W_ident-1:0] unused_cd = {W_ident{1'b1}};

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam logic PIPE0 = 1'b0;
   localparam logic PIPE1 = 1'b1;

endpackage

// File: rtl/resv_prio_pick.sv
// Lowest-index finder over a packed candidate bus; lowest index is the oldest cell.
module resv_prio_pick
   import resv_pkg::*;
(
   input  logic [DEPTH*W_ident-1:0] i_cand,
   output logic                     o_valid,
   output logic [W_ident-1:0]       o_idx
);

   always_comb begin
      // NOTE: defaults come first so every path assigns the outputs and no latch is inferred.
      o_valid = 1'b0;
      o_idx   = unused_cd;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (i_cand[i*W_ident +: W_ident] != unused_cd) begin
            o_valid = 1'b1;
            o_idx   = W_ident'(i);
         end
      end
   end

endmodule

// File: rtl/resv_sched.sv
// Reservation-station controller: occupancy, insert/shift addressing and two-pipe issue arbitration.
// Optional performance counters are built when RESV_SCHED_PERF_EN is defined.
module resv_sched
   import resv_pkg::*;
(
   input  logic                     clk,
   input  logic                     clear,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DEPTH*W_ident-1:0] cand0,
   input  logic [DEPTH*W_ident-1:0] cand1,
   input  logic                     pipe0_ready,
   input  logic                     pipe1_ready,
   output logic                     issue0_fire,
   output logic                     issue1_fire,
   output logic [W_ident-1:0]       issue_idx,
   output logic [W_ident-1:0]       addr_insert,
   output logic [W_ident-1:0]       addr_shift,
   output logic                     cell_clear,
`ifdef RESV_SCHED_PERF_EN
   output logic [31:0]              perf_full_stall,
   output logic [31:0]              perf_issue,
`endif
   output logic [W_cnt-1:0]         count
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_rr;
   logic [W_cnt-1:0]     r_count;

   logic                 w_active;
   logic                 w_v0, w_v1;
   logic [W_ident-1:0]   w_sel0, w_sel1;
   logic                 w_e0, w_e1;
   logic                 w_grant0, w_grant1;
   logic                 w_issue;
   logic                 w_ins;

   resv_prio_pick u_pick0 (
      .i_cand  (cand0),
      .o_valid (w_v0),
      .o_idx   (w_sel0)
   );

   resv_prio_pick u_pick1 (
      .i_cand  (cand1),
      .o_valid (w_v1),
      .o_idx   (w_sel1)
   );

   // State register; clear outranks flush.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (clear) r_state <= RUN;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     w_state_nxt = flush ? DRAIN : RUN;
         DRAIN:   w_state_nxt = flush ? DRAIN : RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   // A flush cycle behaves like a DRAIN cycle: cells cleared, no accept, no issue.
   always_comb begin
      w_active   = (r_state == RUN) && !clear && !flush;
      cell_clear = !w_active;
   end

   // Single shift port in the cells limits issue to one grant per cycle.
   always_comb begin
      w_e0     = w_active && w_v0 && pipe0_ready;
      w_e1     = w_active && w_v1 && pipe1_ready;
      w_grant0 = w_e0 && (!w_e1 || (r_rr == PIPE0));
      w_grant1 = w_e1 && (!w_e0 || (r_rr == PIPE1));
      w_issue  = w_grant0 || w_grant1;

      issue0_fire = w_grant0;
      issue1_fire = w_grant1;
      if (w_grant0)      issue_idx = w_sel0;
      else if (w_grant1) issue_idx = w_sel1;
      else               issue_idx = unused_cd;
      addr_shift = issue_idx;
   end

   // With a simultaneous issue the stack compacts by one, so the new uop lands one slot lower.
   always_comb begin
      in_ready = w_active && ((r_count < W_cnt'(DEPTH)) || w_issue);
      w_ins    = in_valid && in_ready;
      if (w_ins && w_issue) addr_insert = W_ident'(r_count - W_cnt'(1));
      else if (w_ins)       addr_insert = W_ident'(r_count);
      else                  addr_insert = unused_cd;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         r_rr    <= PIPE0;
         r_count <= '0;
      end else begin
         if (w_e0 && w_e1) r_rr <= ~r_rr;
         if (flush) r_count <= '0;
         else       r_count <= r_count + W_cnt'(w_ins) - W_cnt'(w_issue);
      end
   end

   assign count = r_count;

`ifdef RESV_SCHED_PERF_EN
   logic [31:0] r_perf_full_stall;
   logic [31:0] r_perf_issue;

   always_ff @(posedge clk) begin
      if (clear) begin
         r_perf_full_stall <= '0;
         r_perf_issue      <= '0;
      end else begin
         if (in_valid && !in_ready) r_perf_full_stall <= r_perf_full_stall + 32'd1;
         if (w_issue)               r_perf_issue      <= r_perf_issue + 32'd1;
      end
   end

   assign perf_full_stall = r_perf_full_stall;
   assign perf_issue      = r_perf_issue;
`endif

endmodule

// File: tb/tb_resv_sched.sv
// Directed bench for resv_sched: fill, full+issue, oldest-first, round-robin, flush and clear cases.
module tb_resv_sched;

   logic        clk = 1'b0;
   logic        clear, flush, in_valid, pipe0_ready, pipe1_ready;
   logic [31:0] cand0, cand1;
   logic        in_ready, issue0_fire, issue1_fire, cell_clear;
   logic [3:0]  issue_idx, addr_insert, addr_shift, count;
`ifdef RESV_SCHED_PERF_EN
   logic [31:0] perf_full_stall, perf_issue;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   resv_sched dut (
      .clk         (clk),
      .clear       (clear),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .cand0       (cand0),
      .cand1       (cand1),
      .pipe0_ready (pipe0_ready),
      .pipe1_ready (pipe1_ready),
      .issue0_fire (issue0_fire),
      .issue1_fire (issue1_fire),
      .issue_idx   (issue_idx),
      .addr_insert (addr_insert),
      .addr_shift  (addr_shift),
      .cell_clear  (cell_clear),
`ifdef RESV_SCHED_PERF_EN
      .perf_full_stall (perf_full_stall),
      .perf_issue      (perf_issue),
`endif
      .count       (count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Candidate bus with up to two valid slices (negative index = none).
   function automatic logic [31:0] cand_of(input int a, input int b);
      logic [31:0] c;
      c = '1;
      if (a >= 0) c[a*4 +: 4] = 4'(a);
      if (b >= 0) c[b*4 +: 4] = 4'(b);
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_fire(input string tag, input logic f0, input logic f1, input logic [3:0] idx);
      check({tag, "_f0"}, 32'(issue0_fire), 32'(f0));
      check({tag, "_f1"}, 32'(issue1_fire), 32'(f1));
      check({tag, "_idx"}, 32'(issue_idx), 32'(idx));
      check({tag, "_shift"}, 32'(addr_shift), 32'(idx));
   endtask

   initial begin
      clear = 1'b1; flush = 1'b0; in_valid = 1'b1;
      pipe0_ready = 1'b1; pipe1_ready = 1'b0;
      cand0 = cand_of(0, -1); cand1 = '1;
      @(negedge clk);
      check("rst_cell_clear", 32'(cell_clear), 32'd1);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check_fire("rst", 1'b0, 1'b0, 4'hF);
      check("rst_addr_insert", 32'(addr_insert), 32'hF);
      tick();

      // Fill an empty station with no candidates
      clear = 1'b0; cand0 = '1; pipe0_ready = 1'b0;
      settle();
      check("rst_count", 32'(count), 32'd0);
      for (int i = 0; i < 8; i++) begin
         check("fill_in_ready", 32'(in_ready), 32'd1);
         check("fill_addr", 32'(addr_insert), 32'(i));
         check("fill_count", 32'(count), 32'(i));
         check("fill_cell_clear", 32'(cell_clear), 32'd0);
         tick();
      end
      check("full_count", 32'(count), 32'd8);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_addr", 32'(addr_insert), 32'hF);
      tick();
      check("full_hold_count", 32'(count), 32'd8);

      // Full plus issue from cell 3: insert lands at DEPTH-1
      cand0 = cand_of(3, -1); pipe0_ready = 1'b1;
      settle();
      check_fire("full_issue", 1'b1, 1'b0, 4'd3);
      check("full_issue_ready", 32'(in_ready), 32'd1);
      check("full_issue_addr", 32'(addr_insert), 32'd7);
      tick();
      check("full_issue_count", 32'(count), 32'd8);

      // Oldest first on pipe 1
      in_valid = 1'b0; cand0 = '1; pipe0_ready = 1'b0;
      cand1 = cand_of(2, 5); pipe1_ready = 1'b1;
      settle();
      check_fire("oldest", 1'b0, 1'b1, 4'd2);
      check("oldest_addr", 32'(addr_insert), 32'hF);
      tick();
      check("oldest_count", 32'(count), 32'd7);

      // Round-robin with both pipes eligible, rr=0 from reset
      cand0 = cand_of(0, -1); cand1 = cand_of(1, -1);
      pipe0_ready = 1'b1; pipe1_ready = 1'b1;
      settle();
      check_fire("rr_0", 1'b1, 1'b0, 4'd0);
      tick();
      check_fire("rr_1", 1'b0, 1'b1, 4'd1);
      tick();
      check_fire("rr_2", 1'b1, 1'b0, 4'd0);
      tick();
      check_fire("rr_3", 1'b0, 1'b1, 4'd1);
      tick();
      check("rr_count", 32'(count), 32'd3);
      pipe0_ready = 1'b0;
      settle();
      check_fire("rr_p1only", 1'b0, 1'b1, 4'd1);
      tick();
      pipe0_ready = 1'b1;
      settle();
      check_fire("rr_hold", 1'b1, 1'b0, 4'd0);
      tick();
      check("rr_end_count", 32'(count), 32'd1);

      // Refill to 5
      cand0 = '1; cand1 = '1; pipe0_ready = 1'b0; pipe1_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 1; i < 5; i++) begin
         settle();
         check("refill_addr", 32'(addr_insert), 32'(i));
         tick();
      end
      check("refill_count", 32'(count), 32'd5);

      // Issue of top slot plus insert overwrites that slot
      cand0 = cand_of(4, -1); pipe0_ready = 1'b1;
      settle();
      check_fire("top", 1'b1, 1'b0, 4'd4);
      check("top_addr", 32'(addr_insert), 32'd4);
      tick();
      check("top_count", 32'(count), 32'd5);

      // Flush with count=5
      flush = 1'b1; cand0 = cand_of(0, -1);
      settle();
      check("flush_cell_clear", 32'(cell_clear), 32'd1);
      check("flush_in_ready", 32'(in_ready), 32'd0);
      check_fire("flush", 1'b0, 1'b0, 4'hF);
      check("flush_addr", 32'(addr_insert), 32'hF);
      tick();
      flush = 1'b0;
      settle();
      check("drain_cell_clear", 32'(cell_clear), 32'd1);
      check("drain_in_ready", 32'(in_ready), 32'd0);
      check_fire("drain", 1'b0, 1'b0, 4'hF);
      check("drain_count", 32'(count), 32'd0);
      tick();
      cand0 = '1; pipe0_ready = 1'b0;
      settle();
      check("post_flush_cell_clear", 32'(cell_clear), 32'd0);
      check("post_flush_addr", 32'(addr_insert), 32'd0);
      tick();
      check("post_flush_count", 32'(count), 32'd1);

      // Clear during DRAIN
      flush = 1'b1; in_valid = 1'b0;
      tick();
      flush = 1'b0; clear = 1'b1; in_valid = 1'b1;
      settle();
      check("clr_drain_cell_clear", 32'(cell_clear), 32'd1);
      tick();
      clear = 1'b0;
      settle();
      check("clr_drain_run", 32'(cell_clear), 32'd0);
      check("clr_drain_count", 32'(count), 32'd0);
      check("clr_drain_addr", 32'(addr_insert), 32'd0);
      tick();
      check("clr_drain_count1", 32'(count), 32'd1);

      // Clear outranks flush: next cycle is RUN, not DRAIN
      clear = 1'b1; flush = 1'b1; in_valid = 1'b0;
      tick();
      clear = 1'b0; flush = 1'b0;
      settle();
      check("clr_prio_cell_clear", 32'(cell_clear), 32'd0);
      check("clr_prio_count", 32'(count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
